// File: rtl/sram_150b_512_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a 150b x 512 single-port SRAM macro.
// Grants one access per cycle, drives the active-low macro pins from the winning request,
// and returns read data through a one-entry response slot per requester.
module sram_150b_512_arbiter #(
    parameter int DATA_WIDTH = 150,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata,
    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0
);

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_FULL    = 2'd2
    } slot_t;

    slot_t                 slot_q [2];
    slot_t                 slot_d [2];
    logic [DATA_WIDTH-1:0] rdata_q [2];

    logic                  ptr_q;
    logic [1:0]            elig;
    logic                  gnt_vld;
    logic                  gnt_id;
    logic                  gnt_we;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [DATA_WIDTH-1:0] din_hold;

    // Read-tracking pipeline: p0 is the cycle after the access edge, p1 one cycle later.
    logic                  vld_p0;
    logic                  vld_p1;
    logic                  id_p0;
    logic                  id_p1;
    logic                  cap_vld;
    logic                  cap_id;

    // Eligibility and round-robin grant; a read is blocked unless its slot is EMPTY.
    always_comb begin
        elig      = 2'b00;
        gnt_id    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = rst_n & req_valid[i] & (req_we[i] | (slot_q[i] == SLOT_EMPTY));
        end
        gnt_vld = |elig;
        case (elig)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ptr_q;
            default: gnt_id = 1'b0;
        endcase
        gnt_we    = gnt_id ? req_we[1] : req_we[0];
        gnt_addr  = gnt_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        gnt_wdata = gnt_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        req_ready = gnt_vld ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    end

    // Macro pins follow the winner; address and data hold their last value when idle.
    always_comb begin
        sram_csb0  = ~gnt_vld;
        sram_web0  = gnt_vld ? ~gnt_we : 1'b1;
        sram_addr0 = !rst_n ? '0 : (gnt_vld ? gnt_addr : addr_hold);
        sram_din0  = !rst_n ? '0 : (gnt_vld ? gnt_wdata : din_hold);
    end

    // Round-robin pointer and idle-hold registers for the macro address/data pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= 1'b0;
            addr_hold <= '0;
            din_hold  <= '0;
        end else if (gnt_vld) begin
            ptr_q     <= ~gnt_id;
            addr_hold <= gnt_addr;
            din_hold  <= gnt_wdata;
        end
    end

    // Read valid travels down the pipeline; in-flight reads are dropped on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= gnt_vld & ~gnt_we;
            vld_p1 <= vld_p0;
        end
    end

    // Requester id rides alongside the read valid.
    always_ff @(posedge clk) begin
        id_p0 <= gnt_id;
        id_p1 <= id_p0;
    end

    assign cap_vld = (RD_LATENCY == 1) ? vld_p0 : vld_p1;
    assign cap_id  = (RD_LATENCY == 1) ? id_p0  : id_p1;

    // Response slot next state: EMPTY -> PENDING on read grant, -> FULL on capture, -> EMPTY on accept.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                SLOT_EMPTY:   if (gnt_vld && !gnt_we && (gnt_id == 1'(i))) slot_d[i] = SLOT_PENDING;
                SLOT_PENDING: if (cap_vld && (cap_id == 1'(i)))           slot_d[i] = SLOT_FULL;
                SLOT_FULL:    if (rsp_ready[i])                            slot_d[i] = SLOT_EMPTY;
                default:                                                   slot_d[i] = SLOT_EMPTY;
            endcase
        end
    end

    // Response slot state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                slot_q[i] <= SLOT_EMPTY;
            end else begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Capture macro read data into the owning requester's slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cap_vld && (cap_id == 1'(i))) begin
                rdata_q[i] <= sram_dout0;
            end
        end
    end

    assign rsp_valid[0] = rst_n & (slot_q[0] == SLOT_FULL);
    assign rsp_valid[1] = rst_n & (slot_q[1] == SLOT_FULL);
    assign rsp_rdata    = {rdata_q[1], rdata_q[0]};

endmodule

// File: tb/tb_sram_150b_512_arbiter.sv
// Self-checking bench for sram_150b_512_arbiter with a behavioural 1-cycle-latency macro
// and a per-requester scoreboard of expected read data.
module tb_sram_150b_512_arbiter;

    localparam int DW = 150;
    localparam int AW = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [2*DW-1:0] rsp_rdata;
    logic            sram_csb0;
    logic            sram_web0;
    logic [AW-1:0]   sram_addr0;
    logic [DW-1:0]   sram_din0;
    logic [DW-1:0]   sram_dout0;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] mem     [512];
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] sb_exp;

    logic [DW-1:0] dat_d;
    logic [DW-1:0] dat_e;

    always #5 clk = ~clk;

    sram_150b_512_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_csb0 (sram_csb0),
        .sram_web0 (sram_web0),
        .sram_addr0(sram_addr0),
        .sram_din0 (sram_din0),
        .sram_dout0(sram_dout0)
    );

    // Behavioural macro: samples pins on the clock edge, read data valid the next cycle.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else            sram_dout0      <= mem[sram_addr0];
        end
    end

    // Scoreboard: pushes expected data on read grants, checks on response handshakes.
    always @(posedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (rsp_valid[0] && rsp_ready[0]) begin
                vectors++;
                if (q0.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_rsp0: unexpected response %h, none outstanding", rsp_rdata[DW-1:0]);
                end else begin
                    sb_exp = q0.pop_front();
                    if (rsp_rdata[DW-1:0] !== sb_exp) begin
                        miscompares++;
                        $display("FAIL sb_rsp0: got %h want %h", rsp_rdata[DW-1:0], sb_exp);
                    end
                end
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_rsp1: unexpected response %h, none outstanding", rsp_rdata[2*DW-1:DW]);
                end else begin
                    sb_exp = q1.pop_front();
                    if (rsp_rdata[2*DW-1:DW] !== sb_exp) begin
                        miscompares++;
                        $display("FAIL sb_rsp1: got %h want %h", rsp_rdata[2*DW-1:DW], sb_exp);
                    end
                end
            end
            if (req_ready[0]) begin
                if (req_we[0]) ref_mem[req_addr[AW-1:0]] = req_wdata[DW-1:0];
                else           q0.push_back(ref_mem[req_addr[AW-1:0]]);
            end
            if (req_ready[1]) begin
                if (req_we[1]) ref_mem[req_addr[2*AW-1:AW]] = req_wdata[2*DW-1:DW];
                else           q1.push_back(ref_mem[req_addr[2*AW-1:AW]]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b01;
        req_addr  = {9'h01F, 9'h00F};
        req_wdata = {{DW{1'b1}}, {DW{1'b1}}};
        rsp_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_ctrl: csb=%b web=%b ready=%b rsp_valid=%b want 1 1 00 00",
                         sram_csb0, sram_web0, req_ready, rsp_valid);
            end
            vectors++;
            if (sram_addr0 !== '0 || sram_din0 !== '0) begin
                miscompares++;
                $display("FAIL reset_pins: addr=%h din=%h want 0 0", sram_addr0, sram_din0);
            end
        end
        step();
        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        rsp_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (sram_csb0 !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL idle: csb=%b ready=%b rsp_valid=%b want 1 00 00", sram_csb0, req_ready, rsp_valid);
            end
            if (k < 2) step();
        end
    endtask

    task automatic test_write_read();
        step();
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr[AW-1:0]  = 9'h1A5;
        req_wdata[DW-1:0] = dat_d;
        rsp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 ||
            sram_addr0 !== 9'h1A5 || sram_din0 !== dat_d) begin
            miscompares++;
            $display("FAIL wr_grant: ready=%b csb=%b web=%b addr=%h want 01 0 0 1a5", req_ready, sram_csb0, sram_web0, sram_addr0);
        end
        step();
        req_we = 2'b00;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_addr0 !== 9'h1A5) begin
            miscompares++;
            $display("FAIL rd_grant: ready=%b csb=%b web=%b addr=%h want 01 0 1 1a5", req_ready, sram_csb0, sram_web0, sram_addr0);
        end
        step();
        req_valid = 2'b00;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00 || sram_csb0 !== 1'b1 || sram_addr0 !== 9'h1A5) begin
            miscompares++;
            $display("FAIL rd_lat1: rsp_valid=%b csb=%b addr=%h want 00 1 1a5", rsp_valid, sram_csb0, sram_addr0);
        end
        step();
        rsp_ready = 2'b01;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_rdata[DW-1:0] !== dat_d) begin
            miscompares++;
            $display("FAIL rd_lat2: rsp_valid=%b data=%h want 01 %h", rsp_valid, rsp_rdata[DW-1:0], dat_d);
        end
        step();
        rsp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_drain: rsp_valid=%b want 00", rsp_valid);
        end
    endtask

    task automatic test_contention();
        logic [1:0]    exp_rdy;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] d0;
        step();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            d0 = {5{30'(k * 7 + 1)}};
            req_valid = 2'b11;
            req_we    = 2'b11;
            req_addr  = {9'(48 + k), 9'(32 + k)};
            req_wdata = {~d0, d0};
            exp_rdy   = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr  = (k % 2 == 0) ? 9'(32 + k) : 9'(48 + k);
            @(negedge clk);
            vectors++;
            if (req_ready !== exp_rdy || sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== exp_addr) begin
                miscompares++;
                $display("FAIL contention[%0d]: ready=%b csb=%b addr=%h want %b 0 %h",
                         k, req_ready, sram_csb0, sram_addr0, exp_rdy, exp_addr);
            end
        end
        step();
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        step();
        req_valid = 2'b10;
        req_we    = 2'b10;
        req_addr[2*AW-1:AW]  = 9'h000;
        req_wdata[2*DW-1:DW] = dat_e;
        rsp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_wr: ready=%b want 10", req_ready);
        end
        step();
        req_we = 2'b00;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10 || sram_web0 !== 1'b1 || sram_addr0 !== 9'h000) begin
            miscompares++;
            $display("FAIL bp_rd1: ready=%b web=%b addr=%h want 10 1 000", req_ready, sram_web0, sram_addr0);
        end
        step();
        req_addr[2*AW-1:AW] = 9'h1A5;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_pending: ready=%b want 00", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 2'b10 || rsp_rdata[2*DW-1:DW] !== dat_e || req_ready !== 2'b00 || sram_csb0 !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: rsp_valid=%b ready=%b csb=%b data=%h want 10 00 1 %h",
                         k, rsp_valid, req_ready, sram_csb0, rsp_rdata[2*DW-1:DW], dat_e);
            end
        end
        step();
        rsp_ready = 2'b10;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b10 || req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_nobypass: rsp_valid=%b ready=%b want 10 00", rsp_valid, req_ready);
        end
        step();
        rsp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10 || sram_addr0 !== 9'h1A5 || rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_rd2: ready=%b addr=%h rsp_valid=%b want 10 1a5 00", req_ready, sram_addr0, rsp_valid);
        end
        step();
        req_valid = 2'b00;
        step();
        rsp_ready = 2'b10;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b10 || rsp_rdata[2*DW-1:DW] !== dat_d) begin
            miscompares++;
            $display("FAIL bp_rsp2: rsp_valid=%b data=%h want 10 %h", rsp_valid, rsp_rdata[2*DW-1:DW], dat_d);
        end
        step();
        rsp_ready = 2'b00;
    endtask

    task automatic test_mixed();
        logic [DW-1:0] d1;
        step();
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr[AW-1:0] = 9'h1A5;
        rsp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL mix_rd: ready=%b want 01", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            d1 = {5{30'(k * 13 + 5)}};
            req_valid = 2'b11;
            req_we    = 2'b10;
            req_addr  = {9'(64 + k), 9'h000};
            req_wdata = {d1, {DW{1'b0}}};
            @(negedge clk);
            vectors++;
            if (req_ready !== 2'b10 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== 9'(64 + k)) begin
                miscompares++;
                $display("FAIL mix_wr[%0d]: ready=%b csb=%b web=%b addr=%h want 10 0 0 %h",
                         k, req_ready, sram_csb0, sram_web0, sram_addr0, 9'(64 + k));
            end
            if (k >= 1) begin
                vectors++;
                if (rsp_valid !== 2'b01 || rsp_rdata[DW-1:0] !== dat_d) begin
                    miscompares++;
                    $display("FAIL mix_full[%0d]: rsp_valid=%b data=%h want 01 %h", k, rsp_valid, rsp_rdata[DW-1:0], dat_d);
                end
            end
        end
        step();
        rsp_ready = 2'b01;
        req_addr[2*AW-1:AW] = 9'h045;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10 || rsp_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL mix_drain: ready=%b rsp_valid=%b want 10 01", req_ready, rsp_valid);
        end
        step();
        rsp_ready = 2'b00;
        req_addr[2*AW-1:AW] = 9'h046;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01 || sram_web0 !== 1'b1 || sram_addr0 !== 9'h000) begin
            miscompares++;
            $display("FAIL mix_rr: ready=%b web=%b addr=%h want 01 1 000", req_ready, sram_web0, sram_addr0);
        end
        step();
        req_valid = 2'b00;
        step();
        rsp_ready = 2'b01;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_rdata[DW-1:0] !== dat_e) begin
            miscompares++;
            $display("FAIL mix_rsp2: rsp_valid=%b data=%h want 01 %h", rsp_valid, rsp_rdata[DW-1:0], dat_e);
        end
        step();
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid_read();
        step();
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr[AW-1:0] = 9'h1A5;
        rsp_ready = 2'b01;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_rd_grant: ready=%b want 01", req_ready);
        end
        step();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00 || sram_csb0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid: rsp_valid=%b csb=%b want 00 1", rsp_valid, sram_csb0);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_drop[%0d]: rsp_valid=%b want 00", k, rsp_valid);
            end
            step();
        end
        req_valid = 2'b01;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01 || sram_csb0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_resume_grant: ready=%b csb=%b want 01 0", req_ready, sram_csb0);
        end
        step();
        req_valid = 2'b00;
        step();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_rdata[DW-1:0] !== dat_d) begin
            miscompares++;
            $display("FAIL rst_resume_rsp: rsp_valid=%b data=%h want 01 %h", rsp_valid, rsp_rdata[DW-1:0], dat_d);
        end
        step();
        rsp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_resume_drain: rsp_valid=%b want 00", rsp_valid);
        end
    endtask

    initial begin
        dat_d     = {2'b10, {36{4'hA}}, 4'h5};
        dat_e     = {75{2'b01}};
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b00;

        test_reset();
        test_write_read();
        test_contention();
        test_backpressure();
        test_mixed();
        test_reset_mid_read();

        step();
        step();
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: q0=%0d q1=%0d outstanding want 0 0", q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_150b_512_arbiter.md
Name: sram_150b_512_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 150-bit x 512-word single-port (1rw) SRAM macro.
- Accepts read/write requests on valid/ready handshakes and drives the macro's active-low chip-select, write-enable, address and data pins.
- Tracks the macro's read latency and returns read data per requester through a one-entry response buffer with backpressure.
- Sits between the core's producer/consumer datapaths and the black-box macro instance.

Parameters:
- DATA_WIDTH, 150, macro word width.
- ADDR_WIDTH, 9, macro address width (512 words).
- RD_LATENCY, 1, cycles from the access edge until dout0 is valid. Supported values: 1 or 2.

Ports:
- clk  in  1  single clock; also drives the macro clk0.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester grant/accept.
- req_we  in  2  1 = write, 0 = read.
- req_addr  in  2*ADDR_WIDTH  word address; slice i belongs to requester i.
- req_wdata  in  2*DATA_WIDTH  write data; slice i belongs to requester i.
- rsp_valid  out  2  read data valid, per requester.
- rsp_ready  in  2  consumer accepts read data.
- rsp_rdata  out  2*DATA_WIDTH  read data, per requester.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_addr0  out  ADDR_WIDTH  macro address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rsp_valid=0, req_ready=0, sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
  - Round-robin pointer set to requester 0; all response slots EMPTY; in-flight reads discarded.
  - Outputs hold these values for every cycle rst_n is low.
- Response slot state machine, one per requester:
  - States: EMPTY, PENDING, FULL.
  - EMPTY -> PENDING when a read by that requester is granted.
  - PENDING -> FULL after RD_LATENCY+1 edges, when sram_dout0 is captured into the slot.
  - FULL -> EMPTY on the edge where rsp_valid & rsp_ready are both high.
  - rsp_valid = (slot == FULL); rsp_rdata is the slot register, stable while FULL.
- Eligibility:
  - Requester i is eligible if req_valid[i]=1 and either req_we[i]=1 (writes never blocked) or slot i is EMPTY.
  - A read is not eligible while its slot is FULL, even if rsp_ready is high in the same cycle. There is no same-cycle bypass.
- Arbitration:
  - Combinational within a cycle.
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the requester indicated by the pointer is granted.
  - After any grant, the pointer moves to the other requester.
  - At most one req_ready bit is high per cycle; req_ready[i] is high only if requester i is eligible and granted.
- Macro drive during the grant cycle (combinational from the grant):
  - sram_csb0=0; sram_web0 = ~req_we of the winner; addr and din taken from the winner.
  - The macro samples these at the end of the cycle.
  - With no grant: sram_csb0=1, sram_web0=1, addr and din hold their last values (power/toggle saving).
- Latency:
  - Read granted in cycle T: sram_dout0 is valid in cycle T+RD_LATENCY, captured at the end of that cycle, rsp_valid high from cycle T+RD_LATENCY+1.
  - With RD_LATENCY=1 this is a 2-cycle request-to-response latency.
  - Write: completes at the grant edge; no response.
- Throughput: one access per cycle in total. A requester whose slot is FULL and unconsumed is limited to one outstanding read.
- Simultaneous events:
  - Slot accept and new read grant for the same requester cannot occur in the same cycle (eligibility uses the registered slot state).
  - Back-to-back reads from one requester are therefore spaced by response drain.
  - The other requester fills the gaps.
- Ordering: responses per requester are in issue order (one outstanding at a time). No ordering between requesters.
- Read-after-write to the same address: write granted in T, read granted in T+1 or later returns the new data.
- Reset mid-operation: a PENDING read is dropped with no response. A write granted in the same cycle rst_n falls is not guaranteed to be issued; sram_csb0 is forced 1.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> sram_csb0=1, rsp_valid=00, req_ready=00 until a request arrives.
- Write then read, requester 0: write addr 0x1A5 with data 150'h2A...A5, then read 0x1A5 -> rsp_valid[0] rises exactly 2 cycles after the read grant, rsp_rdata slice 0 = the written data.
- Contention: both requesters issue writes continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with requester 0 after reset; sram_csb0=0 every cycle.
- Backpressure: requester 1 reads 0x000 with rsp_ready[1]=0 for 5 cycles while also holding a second read -> rsp_valid[1] stays 1 with stable data, req_ready[1]=0 for the whole time. Raise rsp_ready -> second read granted the next cycle.
- Mixed traffic: requester 0 has a FULL slot and a pending read; requester 1 issues writes -> requester 1 gets every cycle, no stall.
- Reset mid-read: assert rst_n=0 in the cycle after a read grant -> rsp_valid never asserts for that read; normal operation resumes after release.
